// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared single-port RAM between instruction fetch and load/store,
// running each access through a fixed wait-state sequence with a per-port ack.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_MEM} grant_t;

  state_t             state;
  grant_t             grant;
  logic [CNT_W-1:0]   cnt;

  // Stall while a request is outstanding; the registered ack releases it.
  assign stallreq_if  = if_req && !if_ack;
  assign stallreq_mem = mem_req && !mem_ack;

  // Access sequencer: MEM wins in IDLE, a granted access always runs to completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= G_NONE;
      cnt       <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            grant     <= G_MEM;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            ram_be    <= mem_be;
            cnt       <= CNT_W'(WAIT_CYCLES);
            ram_en    <= 1'b1;
            state     <= ACCESS;
          end else if (if_req) begin
            grant     <= G_IF;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_be    <= 4'b1111;
            cnt       <= CNT_W'(WAIT_CYCLES);
            ram_en    <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (grant == G_IF) begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end else begin
              // Stores leave the load data register untouched.
              if (!ram_we) mem_rdata <= ram_rdata;
              mem_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          grant   <= G_NONE;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: three instances (WAIT_CYCLES 1, 0, 15) checked
// against a transaction-level timing and data model with a shadow memory.
module tb_mem_bus_arbiter;

  localparam int RST_C = 1650;

  logic clk = 1'b0;
  logic rst;

  logic [2:0]        if_req, mem_req, mem_we;
  logic [2:0][31:0]  if_addr, mem_addr, mem_wdata;
  logic [2:0][3:0]   mem_be;
  logic [2:0]        if_ack, mem_ack, ram_en, ram_we, stallreq_if, stallreq_mem;
  logic [2:0][31:0]  if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [2:0][3:0]   ram_be;

  logic [31:0] ram_model [3][256];
  logic [31:0] ref_mem   [3][256];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cur_port [3];
  int          grant_c  [3];
  int          free_c   [3];
  int          n_req    [3];
  int          n_ack    [3];
  bit [2:0]    pend_if, pend_mem, ia_now, ma_now;
  logic [31:0] a_addr [3], a_wdata [3], a_rdexp [3];
  logic [31:0] exp_if_rd [3], exp_mem_rd [3];
  logic        a_we [3];
  logic [3:0]  a_be [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WG = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WG)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req[g]),
      .if_addr      (if_addr[g]),
      .if_rdata     (if_rdata[g]),
      .if_ack       (if_ack[g]),
      .mem_req      (mem_req[g]),
      .mem_we       (mem_we[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_be       (mem_be[g]),
      .mem_rdata    (mem_rdata[g]),
      .mem_ack      (mem_ack[g]),
      .ram_en       (ram_en[g]),
      .ram_we       (ram_we[g]),
      .ram_addr     (ram_addr[g]),
      .ram_wdata    (ram_wdata[g]),
      .ram_be       (ram_be[g]),
      .ram_rdata    (ram_rdata[g]),
      .stallreq_if  (stallreq_if[g]),
      .stallreq_mem (stallreq_mem[g])
    );
    assign ram_rdata[g] = ram_model[g][ram_addr[g][9:2]];
  end

  function automatic int wv(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
  endfunction

  task automatic check(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s w=%0d cyc=%0d got=%h exp=%h", tag, wv(g), cyc, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 3; g++) begin
      check("rst_ram_en", g, 32'(ram_en[g]), 32'd0);
      check("rst_ram_we", g, 32'(ram_we[g]), 32'd0);
      check("rst_if_ack", g, 32'(if_ack[g]), 32'd0);
      check("rst_mem_ack", g, 32'(mem_ack[g]), 32'd0);
      check("rst_if_rdata", g, if_rdata[g], 32'd0);
      check("rst_mem_rdata", g, mem_rdata[g], 32'd0);
      check("rst_ram_addr", g, ram_addr[g], 32'd0);
      check("rst_ram_wdata", g, ram_wdata[g], 32'd0);
      check("rst_ram_be", g, 32'(ram_be[g]), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 | ($urandom & 32'h0000_03FC);
  endfunction

  // One clock of stimulus, model update and output comparison for all instances.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int g = 0; g < 3; g++) begin
      int w = wv(g);
      bit e_en, e_ia, e_ma, wi, wm;
      logic [31:0] ia, ma, md;
      logic mw;
      logic [3:0] mb;
      e_en = (cur_port[g] != 0) && (cyc > grant_c[g]) && (cyc <= grant_c[g] + w + 1);
      e_ia = (cur_port[g] == 1) && (cyc == grant_c[g] + w + 2);
      e_ma = (cur_port[g] == 2) && (cyc == grant_c[g] + w + 2);
      if (e_ia) exp_if_rd[g] = a_rdexp[g];
      if (e_ma && !a_we[g]) exp_mem_rd[g] = a_rdexp[g];
      check("ram_en", g, 32'(ram_en[g]), 32'(e_en));
      if (e_en) begin
        check("ram_we", g, 32'(ram_we[g]), 32'(a_we[g]));
        check("ram_addr", g, ram_addr[g], a_addr[g]);
        check("ram_be", g, 32'(ram_be[g]), 32'(a_be[g]));
        if (a_we[g]) check("ram_wdata", g, ram_wdata[g], a_wdata[g]);
      end
      check("if_ack", g, 32'(if_ack[g]), 32'(e_ia));
      check("mem_ack", g, 32'(mem_ack[g]), 32'(e_ma));
      check("if_rdata", g, if_rdata[g], exp_if_rd[g]);
      check("mem_rdata", g, mem_rdata[g], exp_mem_rd[g]);
      ia_now[g] = e_ia;
      ma_now[g] = e_ma;
      if (e_ia) begin cur_port[g] = 0; n_ack[g]++; pend_if[g] = 1'b0; if_req[g] = 1'b0; end
      if (e_ma) begin cur_port[g] = 0; n_ack[g]++; pend_mem[g] = 1'b0; mem_req[g] = 1'b0; end

      wi = 1'b0; wm = 1'b0;
      ia = rand_addr(); ma = rand_addr(); md = $urandom;
      mw = 1'($urandom_range(0, 1)); mb = 4'($urandom_range(0, 15));
      if (cyc == 2) begin wi = 1'b1; ia = 32'h8000_0000; end
      else if (cyc == 10) begin wm = 1'b1; mw = 1'b1; ma = 32'h8040_0004; md = 32'hDEAD_BEEF; mb = 4'b0011; end
      else if (cyc == 40) begin wi = 1'b1; ia = 32'h8000_0004; wm = 1'b1; mw = 1'b0; ma = 32'h8040_0004; end
      else if (cyc >= 60 && cyc < 1200) begin
        wi = 1'($urandom_range(0, 1)); wm = 1'($urandom_range(0, 1));
      end else if (cyc >= 1200 && cyc < 1600) begin
        wi = 1'b1; wm = (cyc % 10 == 0);
      end else if (cyc == RST_C) begin
        wi = 1'b1; ia = 32'h8000_0008;
      end
      if (wi && !pend_if[g] && !e_ia) begin
        if_req[g] = 1'b1; if_addr[g] = ia; pend_if[g] = 1'b1; n_req[g]++;
      end
      if (wm && !pend_mem[g] && !e_ma) begin
        mem_req[g] = 1'b1; mem_addr[g] = ma; mem_we[g] = mw; mem_wdata[g] = md; mem_be[g] = mb;
        pend_mem[g] = 1'b1; n_req[g]++;
      end
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      logic [7:0] idx;
      check("stallreq_if", g, 32'(stallreq_if[g]), 32'(if_req[g] && !ia_now[g]));
      check("stallreq_mem", g, 32'(stallreq_mem[g]), 32'(mem_req[g] && !ma_now[g]));
      // Model arbiter: one access at a time, MEM first, W+3 cycles per access.
      if (cur_port[g] == 0 && cyc >= free_c[g] && (pend_mem[g] || pend_if[g])) begin
        grant_c[g] = cyc;
        free_c[g]  = cyc + wv(g) + 3;
        if (pend_mem[g]) begin
          cur_port[g] = 2;
          a_addr[g] = mem_addr[g]; a_we[g] = mem_we[g]; a_be[g] = mem_be[g]; a_wdata[g] = mem_wdata[g];
        end else begin
          cur_port[g] = 1;
          a_addr[g] = if_addr[g]; a_we[g] = 1'b0; a_be[g] = 4'b1111; a_wdata[g] = '0;
        end
        idx = a_addr[g][9:2];
        if (a_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (a_be[g][b]) ref_mem[g][idx][8*b +: 8] = a_wdata[g][8*b +: 8];
        end else begin
          a_rdexp[g] = ref_mem[g][idx];
        end
      end
      if (ram_en[g] && ram_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[g][b]) ram_model[g][ram_addr[g][9:2]][8*b +: 8] = ram_wdata[g][8*b +: 8];
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = '0; mem_req = '0; mem_we = '0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    pend_if = '0; pend_mem = '0; ia_now = '0; ma_now = '0;
    for (int g = 0; g < 3; g++) begin
      cur_port[g] = 0; grant_c[g] = 0; free_c[g] = 0; n_req[g] = 0; n_ack[g] = 0;
      exp_if_rd[g] = '0; exp_mem_rd[g] = '0;
      a_addr[g] = '0; a_wdata[g] = '0; a_rdexp[g] = '0; a_we[g] = 1'b0; a_be[g] = '0;
      for (int i = 0; i < 256; i++) begin
        logic [31:0] v;
        v = $urandom;
        ram_model[g][i] = v;
        ref_mem[g][i]   = v;
      end
      ram_model[g][0] = 32'h0000_0513;
      ref_mem[g][0]   = 32'h0000_0513;
    end
    #7;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    while (cyc < 1645) run_cycle();
    for (int g = 0; g < 3; g++) check("acks_vs_reqs", g, 32'(n_ack[g]), 32'(n_req[g]));

    // Abort an access mid-flight: everything returns to reset values, no ack follows.
    while (cyc < RST_C + 1) run_cycle();
    rst = 1'b0;
    #1;
    check_reset_outputs();
    if_req = '0; mem_req = '0; pend_if = '0; pend_mem = '0;
    for (int g = 0; g < 3; g++) begin
      cur_port[g] = 0; free_c[g] = 0; exp_if_rd[g] = '0; exp_mem_rd[g] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
